// File: rtl/memdp_arbiter_pkg.sv
// Shared types and defaults for the dual-port memory arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package memdp_arbiter_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 4;
    localparam int DEF_NUM_WR = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } memdp_arb_state_t;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        onehot_to_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                onehot_to_idx = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/memdp_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among N requesters, last winner gets lowest priority.
// Latency: grant is combinational in the request cycle; pointer moves on the clock edge.
// Backpressure: advance=0 forces gnt=0 and freezes the pointer; losers hold req until granted.
//
// Ports: clock, reset (sync, active-high), req[N], advance (grants allowed this cycle),
//        gnt[N] one-hot grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // r_ptr holds the index that currently has highest priority.
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next_ptr;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        gnt        = '0;
        w_found    = 1'b0;
        w_next_ptr = r_ptr;
        w_idx      = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % N);
            if (advance && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
                w_next_ptr = PTR_W'((int'(r_ptr) + k + 1) % N);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/memdp_arbiter.sv
// Arbitrates NUM_RD readers and NUM_WR writers onto a 1R1W memory with write-to-read bypass,
// plus a clear engine that zeroes the memory one word per cycle.
// Latency: grants combinational; read response registered one cycle after the grant.
// Backpressure: losing requesters hold req/addr/data until granted; no grants while busy/reset.
//
// Ports: clock, reset (sync, active-high); rd_req/rd_addr -> rd_gnt; rsp_valid/rsp_id/rsp_data;
//        wr_req/wr_addr/wr_data -> wr_gnt; clear_req -> busy, clear_done.
module memdp_arbiter
    import memdp_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int ID_W   = $clog2(NUM_RD)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_RD-1:0]             rd_req,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]             rd_gnt,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [WIDTH-1:0]              rsp_data,
    input  logic [NUM_WR-1:0]             wr_req,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data,
    output logic [NUM_WR-1:0]             wr_gnt,
    input  logic                          clear_req,
    output logic                          busy,
    output logic                          clear_done
);

    localparam int WID_W = $clog2(NUM_WR);

    memdp_arb_state_t r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic              r_clear_done;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_data;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_arb_en;
    logic [NUM_RD-1:0] w_rd_gnt;
    logic [NUM_WR-1:0] w_wr_gnt;
    logic [ID_W-1:0]   w_rd_idx;
    logic [WID_W-1:0]  w_wr_idx;
    logic              w_rd_fire;
    logic              w_wr_fire;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [WIDTH-1:0]  w_mem_wdata;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [WIDTH-1:0]  w_rd_data;

    // The clear engine owns the write port, so both arbiters are frozen while clearing.
    assign w_arb_en = (r_state == IDLE) && !reset;

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (rd_req),
        .advance (w_arb_en),
        .gnt     (w_rd_gnt)
    );

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (wr_req),
        .advance (w_arb_en),
        .gnt     (w_wr_gnt)
    );

    assign rd_gnt    = w_rd_gnt;
    assign wr_gnt    = w_wr_gnt;
    assign w_rd_idx  = ID_W'(onehot_to_idx(8'(w_rd_gnt)));
    assign w_wr_idx  = WID_W'(onehot_to_idx(8'(w_wr_gnt)));
    assign w_rd_fire = |w_rd_gnt;
    assign w_wr_fire = |w_wr_gnt;

    assign w_mem_we    = (r_state == CLEAR) || w_wr_fire;
    assign w_mem_waddr = (r_state == CLEAR) ? r_clr_cnt : wr_addr[w_wr_idx];
    assign w_mem_wdata = (r_state == CLEAR) ? '0 : wr_data[w_wr_idx];
    assign w_rd_addr   = rd_addr[w_rd_idx];

    // Same-cycle write to the read address forwards the new data.
    assign w_rd_data = (w_mem_we && (w_mem_waddr == w_rd_addr)) ? w_mem_wdata
                                                                : r_mem[w_rd_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clr_cnt    <= '0;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_rsp_valid  <= w_rd_fire;
            r_clear_done <= 1'b0;
            if (w_rd_fire) begin
                r_rsp_id   <= w_rd_idx;
                r_rsp_data <= w_rd_data;
            end
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Further clear_req pulses are deliberately ignored here.
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state      <= IDLE;
                        r_clr_cnt    <= '0;
                        r_busy       <= 1'b0;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign busy       = r_busy;
    assign clear_done = r_clear_done;

endmodule

// File: tb/tb_memdp_arbiter.sv
// Directed bench for memdp_arbiter: vector table plus hand-written clear/reset sequences.
// Latency: checks grants in the request cycle and responses one cycle later.
// Backpressure: n/a (bench).
module tb_memdp_arbiter;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       rd_req;
    logic [3:0][4:0]  rd_addr;
    logic [3:0]       rd_gnt;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [31:0]      rsp_data;
    logic [1:0]       wr_req;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic [1:0]       wr_gnt;
    logic             clear_req;
    logic             busy;
    logic             clear_done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memdp_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done)
    );

    typedef struct {
        logic [3:0]  rq;
        logic [19:0] ra;
        logic [1:0]  wq;
        logic [9:0]  wa;
        logic [63:0] wd;
        logic [3:0]  rg;
        logic [1:0]  wg;
        logic        v;
        logic [1:0]  id;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic [3:0] rq, logic [19:0] ra, logic [1:0] wq,
                                logic [9:0] wa, logic [63:0] wd, logic [3:0] rg,
                                logic [1:0] wg, logic v, logic [1:0] id, logic [31:0] d);
        vec_t t;
        t.rq = rq; t.ra = ra; t.wq = wq; t.wa = wa; t.wd = wd;
        t.rg = rg; t.wg = wg; t.v = v; t.id = id; t.d = d;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
    endtask

    int  busy_cnt;
    logic saw_done;

    initial begin
        // Reset with every requester active: no grants allowed in reset cycles.
        idle_inputs();
        reset  = 1'b1;
        rd_req = 4'b1111;
        wr_req = 2'b11;
        tick();
        tick();
        chk("rst_rd_gnt", 64'(rd_gnt), 64'h0);
        chk("rst_wr_gnt", 64'(wr_gnt), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_clear_done", 64'(clear_done), 64'h0);
        reset = 1'b0;
        wr_req = 2'b00;

        // All readers requesting from reset: strict rotation 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_gnt_%0d", i), 64'(rd_gnt), 64'(4'b0001 << (i % 4)));
            tick();
            chk($sformatf("rr_valid_%0d", i), 64'(rsp_valid), 64'h1);
            chk($sformatf("rr_id_%0d", i), 64'(rsp_id), 64'(i % 4));
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // rd_addr packs {a3,a2,a1,a0}; wr_addr {a1,a0}; wr_data {d1,d0}.
        vecs[0]  = mk(4'b0000, 20'h0, 2'b01, {5'd9, 5'd5}, {32'h1111, 32'hDEADBEEF},
                      4'b0000, 2'b01, 1'b0, 2'd0, 32'h0);
        vecs[1]  = mk(4'b0100, {5'd0, 5'd5, 5'd9, 5'd1}, 2'b00, 10'h0, 64'h0,
                      4'b0100, 2'b00, 1'b1, 2'd2, 32'hDEADBEEF);
        vecs[2]  = mk(4'b0001, {5'd5, 5'd5, 5'd5, 5'd7}, 2'b10, {5'd7, 5'd5},
                      {32'h1234, 32'hBAD0}, 4'b0001, 2'b10, 1'b1, 2'd0, 32'h1234);
        vecs[3]  = mk(4'b0000, 20'h0, 2'b00, 10'h0, 64'h0,
                      4'b0000, 2'b00, 1'b0, 2'd0, 32'h1234);
        vecs[4]  = mk(4'b1111, {5'd5, 5'd3, 5'd7, 5'd5}, 2'b11, {5'd4, 5'd3},
                      {32'hB, 32'hA}, 4'b0010, 2'b01, 1'b1, 2'd1, 32'h1234);
        vecs[5]  = mk(4'b1111, {5'd5, 5'd3, 5'd7, 5'd5}, 2'b11, {5'd4, 5'd3},
                      {32'hB, 32'hA}, 4'b0100, 2'b10, 1'b1, 2'd2, 32'hA);
        vecs[6]  = mk(4'b1001, {5'd4, 5'd3, 5'd7, 5'd7}, 2'b00, 10'h0, 64'h0,
                      4'b1000, 2'b00, 1'b1, 2'd3, 32'hB);
        vecs[7]  = mk(4'b1001, {5'd4, 5'd3, 5'd7, 5'd7}, 2'b00, 10'h0, 64'h0,
                      4'b0001, 2'b00, 1'b1, 2'd0, 32'h1234);
        vecs[8]  = mk(4'b1001, {5'd4, 5'd3, 5'd7, 5'd7}, 2'b00, 10'h0, 64'h0,
                      4'b1000, 2'b00, 1'b1, 2'd3, 32'hB);
        vecs[9]  = mk(4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 2'b01, {5'd0, 5'd9},
                      {32'h77, 32'h55}, 4'b0010, 2'b01, 1'b1, 2'd1, 32'h55);
        vecs[10] = mk(4'b0001, {5'd9, 5'd9, 5'd9, 5'd5}, 2'b00, 10'h0, 64'h0,
                      4'b0001, 2'b00, 1'b1, 2'd0, 32'hDEADBEEF);

        foreach (vecs[n]) begin
            rd_req  = vecs[n].rq;
            rd_addr = vecs[n].ra;
            wr_req  = vecs[n].wq;
            wr_addr = vecs[n].wa;
            wr_data = vecs[n].wd;
            #1;
            chk($sformatf("v%0d_rd_gnt", n), 64'(rd_gnt), 64'(vecs[n].rg));
            chk($sformatf("v%0d_wr_gnt", n), 64'(wr_gnt), 64'(vecs[n].wg));
            tick();
            chk($sformatf("v%0d_rsp_valid", n), 64'(rsp_valid), 64'(vecs[n].v));
            chk($sformatf("v%0d_rsp_id", n), 64'(rsp_id), 64'(vecs[n].id));
            chk($sformatf("v%0d_rsp_data", n), 64'(rsp_data), 64'(vecs[n].d));
        end
        idle_inputs();

        // Fill every word with 0x100+addr.
        for (int a = 0; a < 32; a++) begin
            wr_req     = 2'b01;
            wr_addr[0] = 5'(a);
            wr_data[0] = 32'h100 + 32'(a);
            tick();
        end
        idle_inputs();

        // A read granted in the clear_req cycle still completes.
        clear_req  = 1'b1;
        rd_req     = 4'b0001;
        rd_addr[0] = 5'd5;
        #1;
        chk("clr_start_rd_gnt", 64'(rd_gnt), 64'h1);
        chk("clr_start_busy", 64'(busy), 64'h0);
        tick();
        clear_req = 1'b0;
        chk("clr_start_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("clr_start_rsp_data", 64'(rsp_data), 64'h105);
        chk("clr_busy_first", 64'(busy), 64'h1);
        busy_cnt = 1;
        rd_req   = 4'b1111;
        wr_req   = 2'b11;
        wr_data  = {32'hFFFF, 32'hEEEE};
        for (int c = 0; c < 100; c++) begin
            #1;
            chk($sformatf("clr_rd_gnt_%0d", busy_cnt), 64'(rd_gnt), 64'h0);
            chk($sformatf("clr_wr_gnt_%0d", busy_cnt), 64'(wr_gnt), 64'h0);
            if (busy_cnt == 5) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
            if (!busy) break;
            busy_cnt++;
            chk($sformatf("clr_done_early_%0d", busy_cnt), 64'(clear_done), 64'h0);
        end
        idle_inputs();
        chk("clr_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("clr_done_pulse", 64'(clear_done), 64'h1);
        tick();
        chk("clr_done_one_cycle", 64'(clear_done), 64'h0);

        for (int a = 0; a < 32; a++) begin
            rd_req     = 4'b0001;
            rd_addr[0] = 5'(a);
            tick();
            chk($sformatf("clr_read_%0d", a), 64'(rsp_data), 64'h0);
        end
        idle_inputs();

        // Reset in the 10th busy cycle of a clear.
        wr_req     = 2'b01;
        wr_addr[0] = 5'd20;
        wr_data[0] = 32'h99;
        rd_req     = 4'b0010;
        rd_addr[1] = 5'd20;
        tick();
        chk("pre_abort_bypass", 64'(rsp_data), 64'h99);
        idle_inputs();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        chk("abort_busy_c10", 64'(busy), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(clear_done), 64'h0);
        chk("abort_rsp_data", 64'(rsp_data), 64'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (clear_done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done_later", 64'(saw_done), 64'h0);
        rd_req  = 4'b1111;
        rd_addr = {5'd20, 5'd20, 5'd20, 5'd20};
        wr_req  = 2'b11;
        wr_addr = {5'd31, 5'd31};
        wr_data = {32'h6, 32'h5};
        #1;
        chk("abort_rd_ptr", 64'(rd_gnt), 64'h1);
        chk("abort_wr_ptr", 64'(wr_gnt), 64'h1);
        tick();
        chk("abort_read_zero", 64'(rsp_data), 64'h0);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memdp_arbiter.md
MEMDP_ARBITER -- requirements
Module: memdp_arbiter

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: data word width.
- REQ-002 SHALL have parameter DEPTH, default 32: memory entries; ADDR_W = $clog2(DEPTH).
- REQ-003 SHALL have parameter NUM_RD, default 4: read requesters, legal range 2..8; ID_W = $clog2(NUM_RD).
- REQ-004 SHALL have parameter NUM_WR, default 2: write requesters, legal range 2..8.
- REQ-005 SHALL have port clock, input, 1: clock, all logic on the rising edge.
- REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
- REQ-007 SHALL have port rd_req, input, [NUM_RD]: per-requester read request.
- REQ-008 SHALL have port rd_addr, input, [NUM_RD][ADDR_W]: per-requester read address.
- REQ-009 SHALL have port rd_gnt, output, [NUM_RD]: one-hot read grant, combinational.
- REQ-010 SHALL have port rsp_valid, output, 1: registered read response valid.
- REQ-011 SHALL have port rsp_id, output, [ID_W]: index of the requester that owns the response.
- REQ-012 SHALL have port rsp_data, output, [WIDTH]: registered read data.
- REQ-013 SHALL have port wr_req, input, [NUM_WR]: per-requester write request.
- REQ-014 SHALL have port wr_addr, input, [NUM_WR][ADDR_W]: write address.
- REQ-015 SHALL have port wr_data, input, [NUM_WR][WIDTH]: write data.
- REQ-016 SHALL have port wr_gnt, output, [NUM_WR]: one-hot write grant, combinational.
- REQ-017 SHALL have port clear_req, input, 1: single-cycle pulse that starts a memory clear.
- REQ-018 SHALL have port busy, output, 1: high while the state is CLEAR.
- REQ-019 SHALL have port clear_done, output, 1: one-cycle pulse when a clear completes.

Function
- REQ-020 SHALL own one memory instance, with one read port and one write port, built with read bypass enabled.
- REQ-021 SHALL use the request/grant rule: a requester holds req and its address (and data) stable until granted; grant is valid in the same cycle as req.
- REQ-022 SHALL arbitrate read grants round-robin: after granting i, priority order is i+1, i+2, ... mod NUM_RD, and rd_rr_ptr updates only on a grant.
- REQ-023 SHALL arbitrate write grants round-robin, independently of reads, using the same rules with its own pointer.
- REQ-024 SHALL grant at most one read and one write per cycle, and a read and a write may be granted in the same cycle.
- REQ-025 SHALL register the read result one cycle after the grant: rsp_valid=1, rsp_id=granted index, rsp_data=memory data.
- REQ-026 SHALL, when a same-cycle read and write target the same address, return the new write data (bypass).
- REQ-027 SHALL hold rsp_data at its last value when rsp_valid=0.
- REQ-028 SHALL use FSM states IDLE and CLEAR: IDLE->CLEAR on clear_req; CLEAR->IDLE after the write to address DEPTH-1.
- REQ-029 SHALL, in CLEAR, write zero to address clr_cnt (0..DEPTH-1) each cycle, with clr_cnt incrementing by one per cycle.
- REQ-030 SHALL hold all rd_gnt and wr_gnt at 0 in CLEAR.
- REQ-031 SHALL let a read granted in the cycle of clear_req complete normally on the following cycle.
- REQ-032 SHALL assert clear_done in the cycle the FSM returns to IDLE; a clear takes exactly DEPTH cycles of busy.
- REQ-033 SHALL ignore clear_req while in CLEAR.
- REQ-034 SHALL grant nothing to a requester whose req is 0; all-zero requests give all-zero grants and leave the pointer unchanged.

Reset
- REQ-035 SHALL, on reset, set state=IDLE, clr_cnt=0, both RR pointers=0 (requester 0 highest priority), rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, clear_done=0, and memory contents=0.
- REQ-036 SHALL, on reset during CLEAR, abort the clear immediately with no clear_done pulse.
- REQ-037 SHALL hold all grants at 0 in the reset cycle.

Structure
- REQ-038 SHALL place the state enum (IDLE, CLEAR) in the shared package as memdp_arb_state_t.
- REQ-039 SHALL place the default WIDTH, DEPTH, NUM_RD and NUM_WR constants in the shared package.
- REQ-040 SHALL implement round-robin as one sub-module rr_arbiter (parameter N; ports req, gnt, advance), instantiated once for reads and once for writes.

Verification
- REQ-041 SHALL cover: write 0xDEADBEEF to address 5 from wr 0, then rd 2 reads address 5 -> next cycle rsp_valid=1, rsp_id=2, rsp_data=0xDEADBEEF.
- REQ-042 SHALL cover: rd_req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3.
- REQ-043 SHALL cover: same cycle wr 1 writes 0x1234 to address 7 and rd 0 reads address 7 -> rsp_data=0x1234.
- REQ-044 SHALL cover: fill memory, pulse clear_req -> busy for 32 cycles, grants 0 throughout, clear_done on cycle 32, all reads return 0.
- REQ-045 SHALL cover: reset asserted on cycle 10 of a clear -> busy=0 next cycle, no clear_done, pointers=0, reads return 0.
- REQ-046 SHALL cover: clear_req pulsed again during CLEAR -> ignored, total busy remains 32 cycles.
